// File: rtl/hack_loader_pkg.sv
// Shared types and constants for the Hack ROM byte-stream loader.
// Used by the RTL and by the bench stream driver.
package hack_loader_pkg;

    localparam int ADDR_W_DEFAULT = 10;
    localparam int DATA_W         = 16;

    // Frame byte order: little-endian length and words, low byte first.
    localparam int LO_SHIFT = 0;
    localparam int HI_SHIFT = 8;

    typedef enum logic [3:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        CSUM,
        CHECK,
        RUN,
        ERROR
    } loader_state_t;

    function automatic logic [15:0] join_bytes(input logic [7:0] lo, input logic [7:0] hi);
        return (16'(hi) << HI_SHIFT) | (16'(lo) << LO_SHIFT);
    endfunction

endpackage

// File: rtl/hack_rom_loader.sv
// Writer side of the Hack instruction ROM: assembles a checksummed byte stream into
// 16-bit words, writes them to the ROM port and releases the core on a good load.
module hack_rom_loader
    import hack_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    loader_state_t     state_q, state_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] rom_wdata_q, rom_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic        hs;
    logic [15:0] frame_len;

    // start wins over a byte offered in the same cycle.
    assign in_ready  = (state_q inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM}) && !start;
    assign hs        = in_valid && in_ready;
    assign frame_len = join_bytes(len_lo_q, in_data);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path infers a latch.
        state_d     = state_q;
        lo_d        = lo_q;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        csum_d      = csum_q;
        words_d     = words_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        err_d       = err_q;

        if (start) begin
            state_d    = LEN_LO;
            csum_d     = '0;
            words_d    = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
            cpu_hold_d = 1'b1;
        end else begin
            // The checksum byte is folded in too, so a good frame leaves zero.
            if (hs) csum_d = csum_q ^ in_data;
            unique case (state_q)
                LEN_LO: if (hs) begin
                    len_lo_d = in_data;
                    state_d  = LEN_HI;
                end
                LEN_HI: if (hs) begin
                    len_d = frame_len[ADDR_W:0];
                    if ({1'b0, frame_len} > MAX_WORDS) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else if (frame_len == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA_LO;
                    end
                end
                DATA_LO: if (hs) begin
                    lo_d    = in_data;
                    state_d = DATA_HI;
                end
                DATA_HI: if (hs) begin
                    rom_we_d    = 1'b1;
                    rom_addr_d  = words_q[ADDR_W-1:0];
                    rom_wdata_d = join_bytes(lo_q, in_data);
                    words_d     = words_q + 1'b1;
                    state_d     = (words_q + 1'b1 == len_q) ? CSUM : DATA_LO;
                end
                CSUM: if (hs) state_d = CHECK;
                CHECK: begin
                    if (csum_q == 8'h00) begin
                        state_d    = RUN;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            lo_q        <= '0;
            len_lo_q    <= '0;
            len_q       <= '0;
            csum_q      <= '0;
            words_q     <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            words_q     <= words_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign rom_we       = rom_we_q;
    assign rom_addr     = rom_addr_q;
    assign rom_wdata    = rom_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader: drives byte frames, logs every ROM write
// and compares against the image the bench itself sent.
module tb_hack_rom_loader;
    import hack_loader_pkg::*;

    localparam int AW = 10;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] log_addr[$];
    logic [15:0]   log_data[$];
    logic          prev_we = 1'b0;
    logic          consec  = 1'b0;
    logic [15:0]   img[1024];

    hack_rom_loader #(.ADDR_W(AW)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 Clk = ~Clk;

    // Write monitor, sampled mid-cycle.
    always @(negedge Clk) begin
        if (rom_we) begin
            log_addr.push_back(rom_addr);
            log_data.push_back(rom_wdata);
            if (prev_we) consec = 1'b1;
        end
        prev_we = rom_we;
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        consec = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic sent;
        sent = 1'b0;
        repeat (gap) @(negedge Clk);
        @(negedge Clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 50 && !sent; k++) begin
            if (in_ready) begin
                @(posedge Clk);
                #1;
                sent = 1'b1;
            end else begin
                @(negedge Clk);
            end
        end
        in_valid = 1'b0;
        if (!sent) begin
            n_checks++; n_fail++;
            $display("FAIL send_byte_timeout: byte %h not accepted within 50 cycles, required accept", b);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (rom_we !== 1'b0) begin n_fail++; $display("FAIL reset_rom_we: got %b want 0", rom_we); end
        n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
        n_checks++; if (rom_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_rom_wdata: got %h want 0", rom_wdata); end
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
        n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
        n_checks++; if (words_loaded !== '0) begin n_fail++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
        Reset = 1'b0;
        @(negedge Clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b want 0", in_ready); end
    endtask

    task automatic test_basic();
        clear_log();
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h10, 0);
        @(negedge Clk);
        n_checks++;
        if (rom_we !== 1'b1 || rom_addr !== 10'd0 || rom_wdata !== 16'h1000) begin
            n_fail++; $display("FAIL basic_write_latency: got we=%b addr=%0d data=%h want we=1 addr=0 data=1000", rom_we, rom_addr, rom_wdata);
        end
        send_byte(8'h07, 0); send_byte(8'hEC, 0);
        send_byte(8'hF9, 0);
        repeat (2) @(negedge Clk);
        n_checks++;
        if (log_addr.size() !== 2) begin
            n_fail++; $display("FAIL basic_write_count: got %0d want 2", log_addr.size());
        end else begin
            n_checks++;
            if (log_addr[0] !== 10'd0 || log_data[0] !== 16'h1000 || log_addr[1] !== 10'd1 || log_data[1] !== 16'hEC07) begin
                n_fail++; $display("FAIL basic_writes: got %0d:%h %0d:%h want 0:1000 1:ec07", log_addr[0], log_data[0], log_addr[1], log_data[1]);
            end
        end
        n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL basic_done: got done=%b err=%b want 1 0", done, err); end
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL basic_cpu_hold: got %b want 0", cpu_hold); end
        n_checks++; if (words_loaded !== 11'd2) begin n_fail++; $display("FAIL basic_words: got %0d want 2", words_loaded); end
        n_checks++; if (rom_addr !== 10'd1) begin n_fail++; $display("FAIL basic_addr_held: got %0d want 1", rom_addr); end
    endtask

    task automatic test_bad_csum();
        pulse_start();
        n_checks++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL start_clears: got done=%b hold=%b want 0 1", done, cpu_hold); end
        send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h10, 0); send_byte(8'h07, 0); send_byte(8'hEC, 0);
        send_byte(8'h00, 0);
        repeat (4) @(negedge Clk);
        n_checks++; if (err !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL badcs_err: got err=%b done=%b want 1 0", err, done); end
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL badcs_hold: got %b want 1", cpu_hold); end
        n_checks++; if (dut.state_q !== ERROR) begin n_fail++; $display("FAIL badcs_state: got %0d want %0d", dut.state_q, ERROR); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL badcs_in_ready: got %b want 0", in_ready); end
    endtask

    task automatic test_len_err();
        clear_log();
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h04, 0);
        @(negedge Clk);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL lenerr_err: got %b want 1", err); end
        n_checks++; if (dut.state_q !== ERROR) begin n_fail++; $display("FAIL lenerr_state: got %0d want %0d", dut.state_q, ERROR); end
        repeat (3) @(negedge Clk);
        n_checks++; if (log_addr.size() !== 0) begin n_fail++; $display("FAIL lenerr_no_write: got %0d writes want 0", log_addr.size()); end
    endtask

    task automatic test_full();
        logic [7:0] cs;
        int         bad_idx;
        clear_log();
        cs = 8'h00 ^ 8'h04;
        for (int i = 0; i < 1024; i++) begin
            img[i] = 16'($urandom);
            cs = cs ^ img[i][7:0] ^ img[i][15:8];
        end
        pulse_start();
        send_byte(8'h00, $urandom_range(0, 2));
        send_byte(8'h04, $urandom_range(0, 2));
        for (int i = 0; i < 1024; i++) begin
            send_byte(img[i][7:0], $urandom_range(0, 2));
            send_byte(img[i][15:8], $urandom_range(0, 2));
        end
        send_byte(cs, $urandom_range(0, 2));
        repeat (2) @(negedge Clk);
        n_checks++;
        if (log_addr.size() !== 1024) begin
            n_fail++; $display("FAIL full_write_count: got %0d want 1024", log_addr.size());
        end else begin
            bad_idx = -1;
            for (int i = 0; i < 1024; i++)
                if (bad_idx < 0 && (log_addr[i] !== 10'(i) || log_data[i] !== img[i])) bad_idx = i;
            n_checks++;
            if (bad_idx >= 0) begin
                n_fail++; $display("FAIL full_image: entry %0d got %0d:%h want %0d:%h", bad_idx,
                                   log_addr[bad_idx], log_data[bad_idx], bad_idx, img[bad_idx]);
            end
        end
        n_checks++; if (consec !== 1'b0) begin n_fail++; $display("FAIL full_rate: rom_we in consecutive cycles, want never"); end
        n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL full_done: got done=%b err=%b want 1 0", done, err); end
        n_checks++; if (words_loaded !== 11'd1024) begin n_fail++; $display("FAIL full_words: got %0d want 1024", words_loaded); end
        n_checks++; if (rom_addr !== 10'd1023) begin n_fail++; $display("FAIL full_last_addr: got %0d want 1023", rom_addr); end
    endtask

    task automatic test_restart();
        clear_log();
        pulse_start();
        send_byte(8'h05, 0); send_byte(8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h11 + 8'(i), 0);
            send_byte(8'h21 + 8'(i), 0);
        end
        @(negedge Clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL restart_in_ready: got %b want 0", in_ready); end
        @(negedge Clk);
        start    = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (words_loaded !== '0) begin n_fail++; $display("FAIL restart_words: got %0d want 0", words_loaded); end
        n_checks++; if (dut.state_q !== LEN_LO) begin n_fail++; $display("FAIL restart_state: got %0d want %0d", dut.state_q, LEN_LO); end
        n_checks++; if (log_addr.size() !== 3) begin n_fail++; $display("FAIL restart_partial: got %0d writes want 3", log_addr.size()); end
        clear_log();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h34, 0); send_byte(8'h12, 0);
        send_byte(8'h27, 0);
        repeat (2) @(negedge Clk);
        n_checks++;
        if (log_addr.size() !== 1) begin
            n_fail++; $display("FAIL restart_write_count: got %0d want 1", log_addr.size());
        end else begin
            n_checks++;
            if (log_addr[0] !== 10'd0 || log_data[0] !== 16'h1234) begin
                n_fail++; $display("FAIL restart_write: got %0d:%h want 0:1234", log_addr[0], log_data[0]);
            end
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b want 1", done); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h11, 0);
        @(negedge Clk);
        in_valid = 1'b1;
        in_data  = 8'h22;
        Reset    = 1'b1;
        @(negedge Clk);
        in_valid = 1'b0;
        n_checks++; if (rom_we !== 1'b0) begin n_fail++; $display("FAIL midrst_rom_we: got %b want 0", rom_we); end
        n_checks++;
        if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0 ||
            rom_addr !== '0 || rom_wdata !== 16'h0 || words_loaded !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got rdy=%b hold=%b done=%b err=%b addr=%0d data=%h words=%0d want 0 1 0 0 0 0000 0",
                               in_ready, cpu_hold, done, err, rom_addr, rom_wdata, words_loaded);
        end
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++; if (log_addr.size() !== 0) begin n_fail++; $display("FAIL midrst_spurious: got %0d writes want 0", log_addr.size()); end
        n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d want %0d", dut.state_q, IDLE); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_len_err();
        test_full();
        test_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
